// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the write-through data cache.
// The helpers take the line count as an argument so every user splits addresses identically.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } dcache_state_t;

    function automatic int idx_bits(input int lines);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < lines) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic logic [31:0] idx_of(input logic [31:0] addr, input int lines);
        return (addr >> 2) & 32'(lines - 1);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] addr, input int lines);
        return addr >> (2 + idx_bits(lines));
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache.
// One combinational read port, one synchronous write port, and a synchronous clear of all valid bits.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset; a write coinciding with reset is dropped so an aborted fill leaves no trace.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between the core's M stage and main memory.
// Read hits complete combinationally; misses and stores stall until the memory handshake finishes.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_re,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] read_hits,
    output logic [CNT_W-1:0] read_misses
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    dcache_state_t state, next_state;

    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic             latch_en;
    logic [IDX_W-1:0] cpu_idx, lat_idx, rd_idx;
    logic [TAG_W-1:0] cpu_tag, lat_tag, cmp_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             wr_en;
    logic [31:0]      wr_data;
    logic             hit_inc, miss_inc;

    assign cpu_idx = IDX_W'(idx_of(cpu_addr, LINES));
    assign cpu_tag = TAG_W'(tag_of(cpu_addr, LINES));
    assign lat_idx = IDX_W'(idx_of(lat_addr, LINES));
    assign lat_tag = TAG_W'(tag_of(lat_addr, LINES));

    // While a store is in flight the lookup checks the latched address so the update decision sees the line being written.
    assign rd_idx  = (state == WRITE) ? lat_idx : cpu_idx;
    assign cmp_tag = (state == WRITE) ? lat_tag : cpu_tag;
    assign hit     = rd_valid && (rd_tag == cmp_tag);
    assign cpu_rdata = rd_data;

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (lat_idx),
        .wr_tag   (lat_tag),
        .wr_data  (wr_data)
    );

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        latch_en   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        wr_en      = 1'b0;
        wr_data    = mem_rdata;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_we) begin
                    stall      = 1'b1;
                    latch_en   = 1'b1;
                    next_state = WRITE;
                end else if (cpu_re) begin
                    if (hit) begin
                        hit_inc = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        latch_en   = 1'b1;
                        miss_inc   = 1'b1;
                        next_state = READ;
                    end
                end
            end
            READ: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {lat_addr[31:2], 2'b00};
                if (mem_ready) begin
                    wr_en      = 1'b1;
                    next_state = IDLE;
                end
            end
            WRITE: begin
                stall     = !mem_ready;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {lat_addr[31:2], 2'b00};
                mem_wdata = lat_wdata;
                wr_data   = lat_wdata;
                if (mem_ready) begin
                    wr_en      = hit;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= next_state;
            if (latch_en) begin
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
            end
        end
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_hits   <= '0;
            read_misses <= '0;
        end else begin
            if (hit_inc && (read_hits != '1)) begin
                read_hits <= read_hits + CNT_W'(1);
            end
            if (miss_inc && (read_misses != '1)) begin
                read_misses <= read_misses + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache between the pipelined MIPS core's memory stage and the multi-cycle main data memory. The core presents one load or store per cycle. A read hit returns data combinationally with no stall. Misses and all stores assert `stall` to freeze the pipeline until the main-memory handshake completes.

## Interface
Parameters:
- `LINES`, default 16: number of one-word lines; power of two, ≥2.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `cpu_re`, input, 1: load in M stage.
- `cpu_we`, input, 1: store in M stage (memwrite).
- `cpu_addr`, input, 32: byte address (dataadr); bits [1:0] ignored.
- `cpu_wdata`, input, 32: store data (writedata).
- `cpu_rdata`, output, 32: load data (readdata).
- `stall`, output, 1: freeze pipeline.
- `mem_req`, output, 1: main-memory request.
- `mem_we`, output, 1: request is a write.
- `mem_addr`, output, 32: word-aligned address, bits [1:0]=0.
- `mem_wdata`, output, 32: write data.
- `mem_rdata`, input, 32: read data; valid with `mem_ready`.
- `mem_ready`, input, 1: one-cycle completion pulse.
- `read_hits`, output, CNT_W: saturating load-hit count.
- `read_misses`, output, CNT_W: saturating load-miss count.

## Operation
- Address split: IDX_W=log2(LINES); index=addr[2+:IDX_W]; tag=addr[31:2+IDX_W]. Hit = valid[index] & tag match.
- States: IDLE, READ, WRITE.
- IDLE:
  - `cpu_we`=1 (priority over `cpu_re`): latch addr/wdata, go WRITE, stall=1.
  - `cpu_re` & hit: cpu_rdata=line data, stall=0, read_hits+1.
  - `cpu_re` & miss: latch addr, go READ, stall=1, read_misses+1.
  - Neither asserted: stall=0.
- READ: mem_req=1, mem_we=0, mem_addr=latched. On mem_ready: write mem_rdata, tag, valid=1 into the line, then go IDLE. stall=1 for the whole state. The replayed load hits in the following IDLE cycle; that cycle counts as a hit.
- WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata=latched. On mem_ready: if the latched address hits, update line data; the tag/valid of a missing line are untouched (no allocate). Go IDLE. stall = !mem_ready.
- cpu_rdata outside a read hit: line data at current index (don't-care, deterministic).
- Counters saturate at all-ones; no wrap.
- Addresses differing only in bits [1:0] map to the same word.

## Timing
- Reset (synchronous) clears all valid bits, both counters, and state to IDLE in one cycle.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. stall follows the IDLE equations. cpu_rdata is undefined until the first fill.
- Reset mid-READ/WRITE aborts the transaction: mem_req=0 from the next cycle, no line update, and a late mem_ready is ignored.
- Read-hit latency: 0 cycles, no stall.
- Read-miss stall: 1 (IDLE) + N (READ, until mem_ready inclusive), then data in the next cycle. With memory latency L (mem_ready in the L-th READ cycle), the pipeline stalls L+1 cycles.
- Store stall: 1 (IDLE) + L−1 cycles. The pipeline advances on the mem_ready edge.
- mem_req, mem_we, mem_addr and mem_wdata are registered/state-derived and stable for the whole request. mem_req never deasserts before mem_ready except on reset.
- mem_ready while in IDLE is ignored.

## Structure
- `dcache_pkg`:
  - `dcache_state_t` enum (IDLE, READ, WRITE).
  - Functions `idx_of(addr)` and `tag_of(addr)` parameterised on LINES.
- Sub-module `dcache_array`: valid/tag/data storage, with combinational read port, one synchronous write port (fill or store update), and synchronous clear-all.
- Top: FSM, request latches, counters.

## Test plan
Bench memory model: mem_ready pulses in the 3rd cycle of each request. LINES=16.
1. Reset, then load 0x50 → stall for 4 cycles; mem_addr=0x50, mem_we=0; then rdata = memory word; read_misses=1, read_hits=1.
2. Load 0x50 again → no stall, same data, read_hits=2.
3. Store 0x54 data 4860 (miss) → mem_we=1, mem_wdata=4860, 3 stall cycles; line 5 stays invalid. A following load of 0x54 misses and returns 4860.
4. Store 0x50 data 7 (hit) → line updated. Load 0x50 → 7 with no stall. Then load 0x90 (same index, different tag) → miss evicts. Load 0x50 → miss again.
5. Assert reset in the 2nd READ cycle → mem_req=0 in the next cycle, all lines invalid, counters 0. A stray mem_ready afterwards causes no change.
6. Force read_hits to all-ones with a hit → value holds at all-ones. Load with both cpu_re and cpu_we asserted → treated as a store.
